// File: rtl/seq_divmod.sv
// Sequential restoring divider/modulo unit.
// Produces one quotient bit per clock. Operands can be unsigned or
// two's complement. The remainder can be truncated (sign of a) or
// floored (sign of b).
module seq_divmod #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_en,
  input  logic         floor_mod,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   ma, ma_nxt;          // |a|, shifted out MSB first
  logic [N-1:0]   mb, mb_nxt;          // |b|
  logic [N-1:0]   pr, pr_nxt;          // partial remainder, always < |b|
  logic [N-1:0]   q, q_nxt;            // magnitude quotient
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           sa, sa_nxt;          // a negative (signed mode only)
  logic           sb, sb_nxt;          // b negative (signed mode only)
  logic           fmod, fmod_nxt;      // floored modulo active
  logic           dz, dz_nxt;          // operation is a divide by zero
  logic [N-1:0]   a_raw, a_raw_nxt;
  logic [N-1:0]   b_raw, b_raw_nxt;
  logic [N-1:0]   quotient_nxt, remainder_nxt;
  logic           busy_nxt, done_nxt, div_zero_nxt;

  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     pr_sh;
  logic           ge;
  logic [N-1:0]   pr_sub;
  logic [N-1:0]   q_sgn, r_sgn, q_fix, r_fix;

  // Datapath: operand magnitudes, one restoring step, and final sign/floor fix-up
  always_comb begin
    a_mag  = (signed_en && a[N-1]) ? -a : a;
    b_mag  = (signed_en && b[N-1]) ? -b : b;
    pr_sh  = {pr, ma[N-1]};
    ge     = (pr_sh >= {1'b0, mb});
    pr_sub = pr_sh[N-1:0] - mb;
    q_sgn  = (sa ^ sb) ? -q : q;
    r_sgn  = sa ? -pr : pr;
    q_fix  = q_sgn;
    r_fix  = r_sgn;
    if (fmod && (r_sgn != '0) && (r_sgn[N-1] != sb)) begin
      r_fix = r_sgn + b_raw;
      q_fix = q_sgn - N'(1);
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_nxt     = state;
    ma_nxt        = ma;
    mb_nxt        = mb;
    pr_nxt        = pr;
    q_nxt         = q;
    cnt_nxt       = cnt;
    sa_nxt        = sa;
    sb_nxt        = sb;
    fmod_nxt      = fmod;
    dz_nxt        = dz;
    a_raw_nxt     = a_raw;
    b_raw_nxt     = b_raw;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    div_zero_nxt  = div_zero;

    case (state)
      S_IDLE: begin
        if (start) begin
          ma_nxt       = a_mag;
          mb_nxt       = b_mag;
          pr_nxt       = '0;
          q_nxt        = '0;
          cnt_nxt      = '0;
          sa_nxt       = signed_en & a[N-1];
          sb_nxt       = signed_en & b[N-1];
          fmod_nxt     = signed_en & floor_mod;
          dz_nxt       = (b == '0);
          a_raw_nxt    = a;
          b_raw_nxt    = b;
          div_zero_nxt = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = (b == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        ma_nxt  = {ma[N-2:0], 1'b0};
        pr_nxt  = ge ? pr_sub : pr_sh[N-1:0];
        q_nxt   = {q[N-2:0], ge};
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
        if (dz) begin
          quotient_nxt  = '1;
          remainder_nxt = a_raw;
          div_zero_nxt  = 1'b1;
        end else begin
          quotient_nxt  = q_fix;
          remainder_nxt = r_fix;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ma        <= '0;
      mb        <= '0;
      pr        <= '0;
      q         <= '0;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      fmod      <= 1'b0;
      dz        <= 1'b0;
      a_raw     <= '0;
      b_raw     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ma        <= ma_nxt;
      mb        <= mb_nxt;
      pr        <= pr_nxt;
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      sa        <= sa_nxt;
      sb        <= sb_nxt;
      fmod      <= fmod_nxt;
      dz        <= dz_nxt;
      a_raw     <= a_raw_nxt;
      b_raw     <= b_raw_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      div_zero  <= div_zero_nxt;
    end
  end

endmodule

// File: doc/seq_divmod.md
Name: seq_divmod

Overview:
- Multi-cycle parametrised divider/modulo unit for the ALU.
- Computes quotient and remainder of two N-bit operands with a shift-subtract (restoring) datapath, one quotient bit per clock.
- Supports unsigned or two's-complement operands, and truncated-remainder or floored-modulo semantics.
- Replaces the purely combinational modulo path, which has no signed or floored behaviour, with a start/busy/done handshake so wide N meets timing.

Parameters:
- N, 4: operand/result width in bits; legal range N >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  N  dividend
- b  in  N  divisor
- signed_en  in  1  1 = a, b, quotient and remainder are two's complement
- floor_mod  in  1  1 = remainder takes the sign of b (mathematical mod); 0 = remainder takes the sign of a (truncated); ignored when signed_en=0
- quotient  out  N  registered result
- remainder  out  N  registered result
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; results valid
- div_zero  out  1  last operation had b==0; held until the next accepted start

Behaviour:
- Reset (async, immediate): state=IDLE; quotient, remainder, busy, done, div_zero = 0; internal registers cleared.
- Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE --start--> CALC when b != 0.
  - IDLE --start--> FIX when b == 0.
  - CALC --after N iterations--> FIX.
  - FIX --> IDLE.
- Accept edge E0 (start=1 in IDLE):
  - Latch a, b, signed_en and floor_mod.
  - Form magnitudes |a| and |b| (unsigned mode: raw values). Magnitude of the most-negative value is 2^(N-1), held in N bits unsigned.
  - Record sign_a and sign_b.
  - Clear div_zero. busy=1 after E0.
- CALC, edges E0+1 .. E0+N:
  - Per edge: shift the partial remainder (N+1 bits) left by 1 and bring in the next |a| bit, MSB first.
  - If partial remainder >= |b|: subtract |b| and set the quotient bit to 1; otherwise set it to 0.
  - Iteration counter is ceil(log2(N+1)) bits.
- FIX, edge E0+N+1 (E0+1 for divide by zero):
  - Sign adjust, signed mode only:
    - quotient negated if sign_a XOR sign_b.
    - remainder negated if sign_a.
  - Floor adjust (signed_en=1, floor_mod=1, remainder != 0, sign(remainder) != sign_b): remainder += b, quotient -= 1.
  - Results truncated to N bits.
  - Register quotient and remainder.
  - Outputs after this edge: done=1, busy=0, state=IDLE.
- Latency: done is high in the cycle after E0+N+1 (N+1 cycles after accept); divide by zero takes 1 cycle.
- done is high for exactly one cycle; busy and done are never high together.
- Divide by zero (b==0): quotient = all ones; remainder = a unmodified; div_zero=1. Same in every mode; floor adjust skipped.
- Signed overflow (signed_en=1, a = -2^(N-1), b = -1): quotient = a (wraps); remainder = 0; div_zero=0.
- start while busy or during FIX: ignored; no queueing.
- start asserted in the same cycle done is high: accepted, because state is IDLE. This gives back-to-back throughput of one result per N+2 cycles.
- quotient and remainder hold the last result until the next done; they are not updated mid-operation.
- Operand inputs may change freely after E0.

Test Plan (N=4):
- Unsigned: a=13, b=4, signed_en=0, start for 1 cycle -> busy for 5 cycles, then done for 1 cycle with quotient=3, remainder=1, div_zero=0.
- Signed truncated: a=4'h9 (-7), b=3, signed_en=1, floor_mod=0 -> quotient=4'hE (-2), remainder=4'hF (-1).
- Signed floored: same operands with floor_mod=1 -> quotient=4'hD (-3), remainder=2. Also a=7, b=4'hD (-3), floor_mod=1 -> quotient=4'hD (-3), remainder=4'hE (-2).
- Divide by zero: a=9, b=0, any mode -> done one cycle after accept; quotient=4'hF, remainder=9, div_zero=1. Next valid op (a=6, b=2) clears div_zero and gives quotient=3, remainder=0.
- Overflow and edge operands:
  - a=4'h8, b=4'hF, signed_en=1 -> quotient=4'h8, remainder=0.
  - Unsigned a=15, b=1 -> quotient=15, remainder=0.
  - Unsigned a=2, b=15 -> quotient=0, remainder=2.
- Control:
  - Pulse start again 2 cycles into an op with different operands -> ignored; first result delivered unchanged.
  - Assert rst 3 cycles into an op -> outputs 0 immediately; no done.
  - Restart after reset with a=10, b=3 -> quotient=3, remainder=1.
